// File: rtl/des_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : des_spi_pkg
//  Purpose  : Shared types and constants for the DES-side SPI master.
//             FRAME_BITS - bits per full-duplex frame
//             BIT_CNT_W  - bit-counter width (holds 0..FRAME_BITS)
//             spi_state_t- frame sequencer states
//  Revision : 1.0 - initial release
// ============================================================================
package des_spi_pkg;

  localparam int FRAME_BITS = 64;
  localparam int BIT_CNT_W  = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_FIN   = 3'd5
  } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/des_spi_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : des_spi_master_if
//  Purpose  : Host handshake and SPI pin bundle for des_spi_master.
//             start/tx_data     - frame request and word to send
//             rx_data/busy/done - captured word and frame status
//             sclk/cs_n/mosi    - SPI outputs, miso - SPI input
//             modport master : the SPI controller side
//             modport slave  : the host / serial-peer side
//  Revision : 1.0 - initial release
// ============================================================================
interface des_spi_master_if;
  import des_spi_pkg::*;

  logic                  start;
  logic [FRAME_BITS-1:0] tx_data;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  busy;
  logic                  done;
  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;

  modport master (
    input  start, tx_data, miso,
    output rx_data, busy, done, sclk, cs_n, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  rx_data, busy, done, sclk, cs_n, mosi
  );

endinterface
`default_nettype wire

// File: rtl/des_spi_master_clk_div.sv
`default_nettype none
// ============================================================================
//  Module   : spi_clk_div
//  Purpose  : Half-period divider for the SPI serial clock. Emits a one-cycle
//             tick every HALF_DIV cycles while enabled.
//             clk  - system clock        rst - synchronous active-high reset
//             en   - run enable (counter clears while low)
//             tick - one-cycle pulse on the last cycle of each half period
//  Revision : 1.0 - initial release
// ============================================================================
module spi_clk_div #(
  parameter int HALF_DIV = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int                 c_CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(HALF_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt <= '0;
    end else if (r_cnt == c_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  assign tick = en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/des_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : des_spi_master
//  Purpose  : SPI mode-0 master for 64-bit full-duplex frames, MSB first.
//             clk - system clock        rst - synchronous active-high reset
//             bus - des_spi_master_if.master:
//               start/tx_data in, rx_data/busy/done out,
//               sclk/cs_n/mosi out, miso in
//  Revision : 1.0 - initial release
// ============================================================================
module des_spi_master
  import des_spi_pkg::*;
#(
  parameter int HALF_DIV   = 5,
  parameter int GAP_CYCLES = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  des_spi_master_if.master        bus
);

  localparam int                 c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] c_LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  spi_state_t r_state;
  spi_state_t w_state_nxt;

  logic [FRAME_BITS-1:0] r_tx_sr;
  logic [FRAME_BITS-1:0] r_rx_sr;
  logic [FRAME_BITS-1:0] r_rx_data;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [c_GAP_W-1:0]    r_gap_cnt;
  logic                  r_sclk;
  logic                  r_cs_n;
  logic                  r_mosi;

  logic w_div_en;
  logic w_tick;
  logic w_rise;
  logic w_fall;
  logic w_last_bit;
  logic w_gap_last;
  logic w_busy;
  logic w_done;

  // The divider runs through SETUP, SHIFT and HOLD without restarting, so
  // the HOLD half period lines up with the sclk grid of the shift phase.
  assign w_div_en = (r_state == ST_SETUP) || (r_state == ST_SHIFT) ||
                    (r_state == ST_HOLD);

  spi_clk_div #(
    .HALF_DIV (HALF_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .en   (w_div_en),
    .tick (w_tick)
  );

  // The end of SETUP is the first rising edge; sclk is still low there.
  assign w_rise     = w_tick && !r_sclk &&
                      ((r_state == ST_SETUP) || (r_state == ST_SHIFT));
  assign w_fall     = w_tick && r_sclk && (r_state == ST_SHIFT);
  assign w_last_bit = (r_bit_cnt == c_LAST_BIT);
  assign w_gap_last = (r_gap_cnt == c_GAP_LAST);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        w_busy = 1'b1;
        if (w_tick) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_busy = 1'b1;
        if (w_fall && w_last_bit) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        w_busy = 1'b1;
        if (w_tick) w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        w_busy = 1'b1;
        if (w_gap_last) w_state_nxt = ST_FIN;
      end
      ST_FIN: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_rx_data <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_mosi    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_tx_sr   <= bus.tx_data;
            r_rx_sr   <= '0;
            r_bit_cnt <= '0;
            r_cs_n    <= 1'b0;
            r_mosi    <= bus.tx_data[FRAME_BITS-1];
          end
        end
        ST_SETUP, ST_SHIFT: begin
          if (w_rise) begin
            r_sclk  <= 1'b1;
            r_rx_sr <= {r_rx_sr[FRAME_BITS-2:0], bus.miso};
          end
          if (w_fall) begin
            r_sclk    <= 1'b0;
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            r_tx_sr   <= {r_tx_sr[FRAME_BITS-2:0], 1'b0};
            // After the final bit mosi parks low for HOLD and idle.
            r_mosi    <= w_last_bit ? 1'b0 : r_tx_sr[FRAME_BITS-2];
          end
        end
        ST_HOLD: begin
          if (w_tick) r_cs_n <= 1'b1;
        end
        ST_GAP: begin
          if (w_gap_last) begin
            r_gap_cnt <= '0;
            // Loaded on entry to FIN so rx_data is valid alongside done.
            r_rx_data <= r_rx_sr;
          end else begin
            r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_data = r_rx_data;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.sclk    = r_sclk;
  assign bus.cs_n    = r_cs_n;
  assign bus.mosi    = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_des_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_des_spi_master
//  Purpose  : Scoreboard bench for des_spi_master. Stimulus queues expected
//             frames; a negedge monitor checks each done against the queue,
//             along with frame timing, sclk edge count and the mosi stream.
//             dut0 : HALF_DIV=5, GAP_CYCLES=20 (loopback or slave model)
//             dut1 : HALF_DIV=2, GAP_CYCLES=1  (loopback)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_des_spi_master;
  import des_spi_pkg::*;

  localparam int H0 = 5;
  localparam int G0 = 20;
  localparam int H1 = 2;
  localparam int G1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  des_spi_master_if bus0();
  des_spi_master_if bus1();

  des_spi_master #(.HALF_DIV(H0), .GAP_CYCLES(G0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  des_spi_master #(.HALF_DIV(H1), .GAP_CYCLES(G1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [63:0] rx;
    logic [63:0] tx;
    int          st;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_bad = 0;
  int snap_req = 0;

  // ---------------------------------------------------------- slave model
  logic        lb = 1'b1;
  logic [63:0] slv_word = 64'h0;
  int          slv_idx = 63;
  logic        slv_ps = 1'b0;
  logic        slv_bit = 1'b0;

  assign bus0.miso = lb ? bus0.mosi : slv_bit;
  assign bus1.miso = bus1.mosi;

  always @(negedge clk) begin
    if (bus0.cs_n) slv_idx = 63;
    else if (slv_ps && !bus0.sclk) slv_idx = slv_idx - 1;
    slv_ps  = bus0.sclk;
    slv_bit = (slv_idx >= 0) ? slv_word[slv_idx] : 1'b0;
  end

  // ---------------------------------------------------------- monitor
  logic        pcs[2]        = '{1'b1, 1'b1};
  logic        psclk[2]      = '{1'b0, 1'b0};
  int          cs_fall[2]    = '{0, 0};
  int          cs_rise[2]    = '{0, 0};
  int          first_rise[2] = '{0, 0};
  int          rises[2]      = '{0, 0};
  int          busy_cnt[2]   = '{0, 0};
  logic [63:0] mlog[2]       = '{64'h0, 64'h0};

  logic        m_sclk, m_cs, m_mosi, m_busy, m_done;
  logic [63:0] m_rx;
  int          m_h, m_g, m_qn;
  exp_t        m_e;

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp = n_cmp + 1;
    if (act !== exp_v) begin
      n_bad = n_bad + 1;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, d, cyc, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        m_sclk = bus0.sclk; m_cs = bus0.cs_n; m_mosi = bus0.mosi;
        m_busy = bus0.busy; m_done = bus0.done; m_rx = bus0.rx_data;
        m_h = H0; m_g = G0; m_qn = q0.size();
      end else begin
        m_sclk = bus1.sclk; m_cs = bus1.cs_n; m_mosi = bus1.mosi;
        m_busy = bus1.busy; m_done = bus1.done; m_rx = bus1.rx_data;
        m_h = H1; m_g = G1; m_qn = q1.size();
      end
      if (pcs[d] && !m_cs) begin
        cs_fall[d] = cyc; cs_rise[d] = -1; first_rise[d] = -1;
        rises[d] = 0; busy_cnt[d] = 0; mlog[d] = 64'h0;
      end
      if (!pcs[d] && m_cs) cs_rise[d] = cyc;
      if (!psclk[d] && m_sclk) begin
        if (!m_cs) rises[d] = rises[d] + 1;
        if (first_rise[d] < 0) first_rise[d] = cyc;
        mlog[d] = {mlog[d][62:0], m_mosi};
      end
      if (m_busy) busy_cnt[d] = busy_cnt[d] + 1;
      if (m_done) begin
        if (m_qn == 0) begin
          n_cmp = n_cmp + 1;
          n_bad = n_bad + 1;
          $display("FAIL unexpected_done dut%0d cycle %0d: got done=1 expected none", d, cyc);
        end else begin
          if (d == 0) m_e = q0.pop_front();
          else        m_e = q1.pop_front();
          chk("rx_data",     d, m_rx, m_e.rx);
          chk("mosi_log",    d, mlog[d], m_e.tx);
          chk("done_cycle",  d, 64'(cyc - m_e.st), 64'(1 + 129 * m_h + m_g));
          chk("cs_fall",     d, 64'(cs_fall[d] - m_e.st), 64'd1);
          chk("first_rise",  d, 64'(first_rise[d] - m_e.st), 64'(1 + m_h));
          chk("cs_rise",     d, 64'(cs_rise[d] - m_e.st), 64'(1 + 129 * m_h));
          chk("rise_count",  d, 64'(rises[d]), 64'd64);
          chk("busy_cycles", d, 64'(busy_cnt[d]), 64'(129 * m_h + m_g));
        end
      end
      pcs[d]   = m_cs;
      psclk[d] = m_sclk;
    end
    if (snap_req == 1) begin
      chk("idle_pins", 0, {59'b0, bus0.sclk, bus0.cs_n, bus0.mosi, bus0.busy, bus0.done}, 64'h8);
      chk("idle_rx",   0, bus0.rx_data, 64'h0);
      chk("idle_pins", 1, {59'b0, bus1.sclk, bus1.cs_n, bus1.mosi, bus1.busy, bus1.done}, 64'h8);
    end
    if (snap_req == 2) begin
      chk("queue_empty", 0, 64'(q0.size() + q1.size()), 64'h0);
    end
  end

  // ---------------------------------------------------------- stimulus
  task automatic frame(input int d, input logic [63:0] tx, input logic [63:0] rx,
                       input bit push, output int st);
    exp_t e;
    @(negedge clk);
    if (d == 0) begin bus0.tx_data = tx; bus0.start = 1'b1; end
    else        begin bus1.tx_data = tx; bus1.start = 1'b1; end
    st = cyc;
    e.rx = rx; e.tx = tx; e.st = cyc;
    if (push) begin
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    while (!((d == 0) ? bus0.done : bus1.done)) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        $display("FAIL done_timeout dut%0d cycle %0d: got no done expected one", d, cyc);
        $fatal(1, "frame did not complete");
      end
    end
    @(negedge clk);
  endtask

  task automatic snap(input int kind);
    @(posedge clk); #1 snap_req = kind;
    @(posedge clk); #1 snap_req = 0;
  endtask

  initial begin
    int st;
    bus0.start = 1'b0; bus0.tx_data = 64'h0;
    bus1.start = 1'b0; bus1.tx_data = 64'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    snap(1);

    // Loopback.
    lb = 1'b1;
    frame(0, 64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 1'b1, st);
    wait_done(0);

    // Slave model returning a fixed word.
    lb = 1'b0;
    slv_word = 64'h0123456789ABCDEF;
    frame(0, 64'hA5A50000FFFF1234, 64'h0123456789ABCDEF, 1'b1, st);
    wait_done(0);

    // Start pulses mid-frame must be ignored.
    lb = 1'b1;
    frame(0, 64'h0F1E2D3C4B5A6978, 64'h0F1E2D3C4B5A6978, 1'b1, st);
    while (cyc < st + 100) @(negedge clk);
    bus0.tx_data = 64'h5555AAAA5555AAAA; bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    while (cyc < st + 400) @(negedge clk);
    bus0.tx_data = 64'hFFFFFFFF00000000; bus0.start = 1'b1;
    @(negedge clk); bus0.start = 1'b0;
    wait_done(0);

    // Reset mid-frame: abandoned, no done, pins back to idle next cycle.
    frame(0, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0, st);
    while (cyc < st + 300) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 snap_req = 1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1 snap_req = 0;
    repeat (700) @(negedge clk);
    frame(0, 64'h1111111111111111, 64'h1111111111111111, 1'b1, st);
    wait_done(0);

    // Minimum divider and gap.
    frame(1, 64'h8000000000000001, 64'h8000000000000001, 1'b1, st);
    wait_done(1);

    repeat (5) @(negedge clk);
    snap(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cycle %0d: got no finish expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
